// File: rtl/dac_update_scheduler.sv
// dac_update_scheduler: round-robin sharing of one single-transaction DAC writer across N_CH channels
module dac_update_scheduler #(
  parameter int N_CH           = 2,
  parameter int CH_W           = 1,
  parameter int REFRESH_CYCLES = 1000000,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH-1:0]      req_i,
  input  logic [12*N_CH-1:0]   value_i,
  output logic [N_CH-1:0]      ack_o,
  output logic                 wr_start_o,
  output logic [CH_W-1:0]      wr_channel_o,
  output logic [11:0]          wr_value_o,
  input  logic                 wr_busy_i,
  output logic                 sched_busy_o,
  output logic                 timeout_err_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACCEPT, WAIT_DONE} state_t;
  state_t                 state_q, state_d;
  logic [N_CH-1:0]        pending_q, pending_d, ack_q, ack_d;
  logic [N_CH-1:0][11:0]  last_q, last_d;
  logic [CH_W-1:0]        rr_q, rr_d, ch_q, ch_d, gnt;
  logic [11:0]            val_q, val_d;
  logic [31:0]            ref_q, ref_d, tmo_q, tmo_d;
  logic                   err_q, err_d, tick, expired;
  int                     j;
  // Refresh counter: the wrap cycle marks every channel for a rewrite
  always_comb begin
    tick  = (REFRESH_CYCLES != 0) && (ref_q == 32'(REFRESH_CYCLES - 1));
    ref_d = (REFRESH_CYCLES == 0 || tick) ? '0 : ref_q + 32'd1;
  end
  // Grant: first pending channel at or after the rr pointer, wrapping around
  always_comb begin
    gnt = rr_q;
    j   = 0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      j = int'(rr_q) + i;
      if (j >= N_CH) j = j - N_CH;
      if (pending_q[j]) gnt = CH_W'(j);
    end
  end
  // Writer sequencing FSM with per-state timeout
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    val_d   = val_q;
    rr_d    = rr_q;
    last_d  = last_q;
    ack_d   = '0;
    err_d   = err_q;
    expired = tmo_q >= 32'(TIMEOUT_CYCLES - 1);
    case (state_q)
      IDLE: if (|pending_q) begin
        state_d = ISSUE;
        ch_d    = gnt;
        val_d   = value_i[12*gnt +: 12];
      end
      ISSUE: state_d = WAIT_ACCEPT;
      WAIT_ACCEPT: if (wr_busy_i) state_d = WAIT_DONE;
        else if (expired) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      WAIT_DONE: if (!wr_busy_i) begin
          state_d       = IDLE;
          ack_d[ch_q]   = 1'b1;
          last_d[ch_q]  = val_q;
          rr_d          = (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + 1'b1;
        end else if (expired) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      default: state_d = IDLE;
    endcase
    tmo_d = (state_d != state_q) ? '0 : tmo_q + 32'd1;
  end
  // Pending flags: any set source beats the ack clear; compare against the value being committed
  always_comb begin
    for (int k = 0; k < N_CH; k++)
      pending_d[k] = req_i[k] | (value_i[12*k +: 12] != last_d[k]) | tick | (pending_q[k] & ~ack_d[k]);
  end
  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      ack_q     <= '0;
      last_q    <= '0;
      rr_q      <= '0;
      ch_q      <= '0;
      val_q     <= '0;
      ref_q     <= '0;
      tmo_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ack_q     <= ack_d;
      last_q    <= last_d;
      rr_q      <= rr_d;
      ch_q      <= ch_d;
      val_q     <= val_d;
      ref_q     <= ref_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
    end
  end
  assign ack_o         = ack_q;
  assign wr_start_o    = state_q == ISSUE;
  assign wr_channel_o  = ch_q;
  assign wr_value_o    = val_q;
  assign sched_busy_o  = state_q != IDLE;
  assign timeout_err_o = err_q;
endmodule

// File: tb/tb_dac_update_scheduler.sv
// tb_dac_update_scheduler: directed checks of arbitration, snapshotting, timeout, reset and refresh
module tb_dac_update_scheduler;
  logic        clk = 1'b0, rst = 1'b0, rst_b = 1'b0;
  logic [1:0]  req_a = '0, ack_a, req_b = '0, ack_b;
  logic [23:0] value_a = '0, value_b = {12'h222, 12'h111};
  logic        ws_a, ws_b, busy_a, busy_b, sb_a, sb_b, err_a, err_b;
  logic [0:0]  ch_a, ch_b;
  logic [11:0] val_a, val_b;
  int          checks = 0, passed = 0;
  int          dly_a = 1, len_a = 3, cnt_a = 0, cnt_b = 0;
  bit          dead_a = 0, act_a = 0, act_b = 0;

  dac_update_scheduler #(.N_CH(2), .CH_W(1), .REFRESH_CYCLES(0), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req_i(req_a), .value_i(value_a), .ack_o(ack_a),
    .wr_start_o(ws_a), .wr_channel_o(ch_a), .wr_value_o(val_a), .wr_busy_i(busy_a),
    .sched_busy_o(sb_a), .timeout_err_o(err_a));

  dac_update_scheduler #(.N_CH(2), .CH_W(1), .REFRESH_CYCLES(64), .TIMEOUT_CYCLES(16)) dut_r (
    .clk(clk), .rst(rst_b), .req_i(req_b), .value_i(value_b), .ack_o(ack_b),
    .wr_start_o(ws_b), .wr_channel_o(ch_b), .wr_value_o(val_b), .wr_busy_i(busy_b),
    .sched_busy_o(sb_b), .timeout_err_o(err_b));

  always #5 clk = ~clk;

  // Writer model A: busy rises dly_a cycles after the start pulse and stays len_a cycles
  always @(posedge clk) begin
    if (!rst) begin
      busy_a <= 1'b0; act_a <= 1'b0; cnt_a <= 0;
    end else if (act_a) begin
      cnt_a  <= cnt_a + 1;
      busy_a <= (cnt_a + 1 >= dly_a) && (cnt_a + 1 < dly_a + len_a);
      if (cnt_a + 1 >= dly_a + len_a) act_a <= 1'b0;
    end else if (ws_a && !dead_a) begin
      act_a <= 1'b1; cnt_a <= 0;
    end
  end

  // Writer model B: fixed one-cycle delay, two-cycle busy
  always @(posedge clk) begin
    if (!rst_b) begin
      busy_b <= 1'b0; act_b <= 1'b0; cnt_b <= 0;
    end else if (act_b) begin
      cnt_b  <= cnt_b + 1;
      busy_b <= (cnt_b + 1 >= 1) && (cnt_b + 1 < 3);
      if (cnt_b + 1 >= 3) act_b <= 1'b0;
    end else if (ws_b) begin
      act_b <= 1'b1; cnt_b <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_start(input string tag, input int ech, input logic [11:0] ev);
    int n = 0;
    do begin @(negedge clk); n++; end while (!ws_a && n < 200);
    check({tag, "_seen"}, 32'(ws_a), 1);
    check({tag, "_ch"}, 32'(ch_a), ech);
    check({tag, "_val"}, 32'(val_a), 32'(ev));
  endtask

  task automatic wait_ack(input string tag, input logic [1:0] ea);
    int n = 0;
    do begin @(negedge clk); n++; end while (ack_a == 2'b00 && n < 200);
    check(tag, 32'(ack_a), 32'(ea));
  endtask

  task automatic wait_busy(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (!busy_a && n < 200);
    check(tag, 32'(busy_a), 1);
  endtask

  task automatic drain(input string tag);
    int idle = 0, n = 0;
    while (idle < 6 && n < 400) begin
      @(negedge clk); n++;
      idle = (sb_a || ws_a) ? 0 : idle + 1;
    end
    check(tag, idle, 6);
  endtask

  initial begin
    int k, nb;
    int gch[8], gt[8];
    repeat (3) @(negedge clk);
    check("rst_sched_busy", 32'(sb_a), 0);
    check("rst_wr_start", 32'(ws_a), 0);
    check("rst_ack", 32'(ack_a), 0);
    check("rst_wr_channel", 32'(ch_a), 0);
    check("rst_wr_value", 32'(val_a), 0);
    check("rst_timeout_err", 32'(err_a), 0);
    check("rst_b_sched_busy", 32'(sb_b), 0);

    rst = 1'b1;
    @(negedge clk);
    req_a = 2'b01; value_a[11:0] = 12'h0A5;
    @(negedge clk);
    req_a = 2'b00;
    check("t1_cycle1_start", 32'(ws_a), 0);
    @(negedge clk);
    check("t1_cycle2_start", 32'(ws_a), 1);
    check("t1_cycle2_ch", 32'(ch_a), 0);
    check("t1_cycle2_val", 32'(val_a), 12'h0A5);
    check("t1_cycle2_busy", 32'(sb_a), 1);
    wait_busy("t1_busy_rise");
    k = 0;
    do begin @(negedge clk); k++; end while (busy_a && k < 50);
    check("t1_busy_fall_ack", 32'(ack_a), 0);
    @(negedge clk);
    check("t1_ack", 32'(ack_a), 2'b01);
    check("t1_ack_idle", 32'(sb_a), 0);
    @(negedge clk);
    check("t1_ack_pulse", 32'(ack_a), 0);
    drain("t1_no_rewrite");

    req_a = 2'b11;
    wait_start("t2_g0", 1, 12'h000);
    wait_start("t2_g1", 0, 12'h0A5);
    wait_start("t2_g2", 1, 12'h000);
    wait_start("t2_g3", 0, 12'h0A5);
    req_a = 2'b00;
    drain("t2_drain");

    value_a[23:12] = 12'h100;
    wait_start("t3_first", 1, 12'h100);
    wait_busy("t3_busy");
    value_a[23:12] = 12'h200;
    @(negedge clk);
    check("t3_held_val", 32'(val_a), 12'h100);
    wait_ack("t3_ack1", 2'b10);
    wait_start("t3_second", 1, 12'h200);
    wait_ack("t3_ack2", 2'b10);
    drain("t3_drain");

    dead_a = 1'b1;
    value_a[11:0] = 12'h333;
    wait_start("t4_issue", 0, 12'h333);
    k = 0;
    do begin @(negedge clk); k++; end while (sb_a && k < 40);
    check("t4_timeout_cycles", k, 17);
    check("t4_err_set", 32'(err_a), 1);
    dead_a = 1'b0;
    wait_start("t4_retry", 0, 12'h333);
    wait_ack("t4_retry_ack", 2'b01);
    check("t4_err_sticky", 32'(err_a), 1);
    drain("t4_drain");

    len_a = 20;
    value_a[23:12] = 12'h0AA;
    wait_start("t5_issue", 1, 12'h0AA);
    wait_busy("t5_busy");
    repeat (2) @(negedge clk);
    rst = 1'b0; value_a = '0;
    @(negedge clk);
    check("t5_sched_busy", 32'(sb_a), 0);
    check("t5_wr_start", 32'(ws_a), 0);
    check("t5_ack", 32'(ack_a), 0);
    check("t5_wr_channel", 32'(ch_a), 0);
    check("t5_wr_value", 32'(val_a), 0);
    check("t5_err_cleared", 32'(err_a), 0);
    rst = 1'b1; len_a = 3;
    drain("t5_pending_cleared");
    value_a[23:12] = 12'h055;
    wait_start("t5_value_write", 1, 12'h055);
    wait_ack("t5_ack_after", 2'b10);

    nb = 0;
    @(negedge clk);
    rst_b = 1'b1;
    for (int c = 1; c <= 180; c++) begin
      @(negedge clk);
      if (ws_b && nb < 8) begin
        gch[nb] = int'(ch_b); gt[nb] = c; nb++;
      end
    end
    check("t6_write_count", nb, 6);
    check("t6_first_time", gt[0], 2);
    check("t6_refresh1_time", gt[2], 65);
    check("t6_refresh2_time", gt[4], 129);
    for (int i = 0; i < 6; i++) check($sformatf("t6_grant%0d", i), gch[i], i % 2);
    check("t6_no_error", 32'(err_b), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
